ifetch_ctrl: RTL and testbench
==============================

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 SHALL have parameter: DEPTH, 2, prefetch buffer entries (2..4).
REQ-002 SHALL have parameter: RESET_PC, 8'h00, byte address of first fetch after reset.
REQ-003 SHALL have port: CLK  in  1  clock, all state updates on rising edge.
REQ-004 SHALL have port: RESET  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port: IM_ADDR  out  8  byte address to instruction RAM; bit 0 always 0.
REQ-006 SHALL have port: IM_Q  in  16  instruction RAM read data, combinational from IM_ADDR, same cycle.
REQ-007 SHALL have port: DEC_VALID  out  1  head entry valid to decode.
REQ-008 SHALL have port: DEC_READY  in  1  decode accepts head entry.
REQ-009 SHALL have port: DEC_INSTR  out  16  head instruction.
REQ-010 SHALL have port: DEC_PC  out  8  byte address of head instruction.
REQ-011 SHALL have port: REDIR_VALID  in  1  branch/jump redirect request, single-cycle.
REQ-012 SHALL have port: REDIR_PC  in  8  redirect target byte address.
REQ-013 SHALL have port: RESUME  in  1  leave HALT state, continue fetch.
REQ-014 SHALL have port: HALTED  out  1  fetch stopped and buffer drained.

Function
REQ-015 SHALL hold fetch PC register; IM_ADDR = PC combinationally.
REQ-016 SHALL use states RUN, HALT_WAIT, HALT; RUN fetches, HALT_WAIT/HALT do not.
REQ-017 SHALL push {PC, IM_Q} into buffer in RUN when count < DEPTH or a pop occurs same cycle; PC <= PC + 2, modulo 256 (8'hFE wraps to 8'h00).
REQ-018 SHALL pop head when DEC_VALID && DEC_READY; DEC_VALID = (count != 0).
REQ-019 SHALL hold DEC_INSTR/DEC_PC stable while DEC_VALID && !DEC_READY; drive 0 on both when empty.
REQ-020 SHALL deliver in order; fetch-to-DEC_VALID latency 1 cycle (push registered, no bypass).
REQ-021 SHALL detect pushed IM_Q == 16'h0001 (HALT): push it, then RUN -> HALT_WAIT, no further fetch, PC left at halt address + 2.
REQ-022 SHALL transition HALT_WAIT -> HALT when buffer empty; HALTED = (state == HALT).
REQ-023 SHALL on RESUME in HALT go to RUN, fetching from current PC next cycle; RESUME ignored in RUN/HALT_WAIT.
REQ-024 SHALL on REDIR_VALID: flush all entries, PC <= {REDIR_PC[7:1], 1'b0}, state <= RUN, no push that cycle; fetch of target in following cycle.
REQ-025 SHALL honour a pop coinciding with REDIR_VALID (entry consumed), then flush remainder.
REQ-026 SHALL give REDIR_VALID priority over RESUME and over HALT detection in the same cycle.
REQ-027 SHALL never overflow (push blocked when full without pop) nor underflow (pop only when valid).

Reset
REQ-028 SHALL on RESET: PC <= RESET_PC, count <= 0, state <= RUN, DEC_VALID = 0, DEC_INSTR = 0, DEC_PC = 0, HALTED = 0.
REQ-029 SHALL abandon any in-flight entries, redirect or halt on RESET mid-operation; no push during RESET cycles.
REQ-030 SHALL issue first fetch (IM_ADDR = RESET_PC) in first cycle with RESET low; instruction RAM contents are valid from that cycle.

Structure
REQ-031 SHALL place in shared package ifetch_pkg: HALT_INSTR = 16'h0001, PC_W = 8, INSTR_W = 16, state enum {RUN, HALT_WAIT, HALT}.
REQ-032 SHALL instantiate one sub-module fetch_fifo: DEPTH-entry, 24-bit-wide, synchronous flush, push/pop same cycle when full permitted.

Verification
REQ-033 SHALL cover: reset release, DEC_READY=1 -> DEC_PC sequence 00,02,04,... one per cycle from cycle 1 after release, DEC_INSTR = RAM words 0,1,2.
REQ-034 SHALL cover: DEC_READY=0 for 5 cycles -> exactly 2 entries buffered (PC 00,02), IM_ADDR stalls at 04, outputs stable; READY=1 -> 00,02,04 with no gap.
REQ-035 SHALL cover: REDIR_VALID with REDIR_PC=8'h29 while 2 entries buffered -> buffer flushed, next DEC_PC = 8'h28, no stale 02/04 delivered.
REQ-036 SHALL cover: 16'h0001 at word 29 -> DEC_PC 8'h3A delivered last, HALTED=1 one cycle after buffer drains, IM_ADDR frozen at 8'h3C; RESUME -> next DEC_PC 8'h3C.
REQ-037 SHALL cover: PC at 8'hFE -> next DEC_PC 8'h00 (wrap); RESET asserted mid-stall -> DEC_VALID=0 next cycle, restart from 8'h00.
REQ-038 SHALL cover: REDIR_VALID and RESUME same cycle in HALT -> RUN, fetch from redirect target, RESUME ignored.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch controller.
//   PC_W       : width of byte addresses into instruction RAM
//   INSTR_W    : width of one instruction word
//   HALT_INSTR : opcode that stops fetch once it has been buffered
//   state_t    : fetch FSM states
package ifetch_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 16'h0001;

  typedef enum logic [1:0] {
    RUN,
    HALT_WAIT,
    HALT
  } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO with synchronous flush.
//   CLK, RESET : clock, synchronous active-high reset
//   flush      : drop all entries (any pop in the same cycle is still consumed)
//   push       : write push_data; accepted when not full or when popping
//   pop        : consume head; ignored when empty
//   valid      : at least one entry present
//   full       : DEPTH entries present
//   head_data  : oldest entry, zero when empty
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 24
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid     = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && valid;
  assign do_push   = push && (!full || do_pop);
  assign head_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: fetches 16-bit words from a combinational
// instruction RAM into a small prefetch buffer feeding decode.
//   CLK, RESET  : clock, synchronous active-high reset
//   IM_ADDR     : fetch byte address (always even)
//   IM_Q        : RAM read data for IM_ADDR, same cycle
//   DEC_VALID   : head entry valid
//   DEC_READY   : decode accepts head entry
//   DEC_INSTR   : head instruction (0 when empty)
//   DEC_PC      : head byte address (0 when empty)
//   REDIR_VALID : single-cycle redirect; flushes buffer, restarts at REDIR_PC
//   REDIR_PC    : redirect target byte address (bit 0 ignored)
//   RESUME      : leave HALT and continue fetching from the held PC
//   HALTED      : fetch stopped after a HALT instruction and buffer drained
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input  logic                CLK,
  input  logic                RESET,
  output logic [PC_W-1:0]     IM_ADDR,
  input  logic [INSTR_W-1:0]  IM_Q,
  output logic                DEC_VALID,
  input  logic                DEC_READY,
  output logic [INSTR_W-1:0]  DEC_INSTR,
  output logic [PC_W-1:0]     DEC_PC,
  input  logic                REDIR_VALID,
  input  logic [PC_W-1:0]     REDIR_PC,
  input  logic                RESUME,
  output logic                HALTED
);

  localparam logic [PC_W-1:0] ALIGN_MASK = 8'hFE;

  state_t                    state;
  state_t                    state_nxt;
  logic [PC_W-1:0]           pc;
  logic [PC_W-1:0]           pc_nxt;
  logic                      push;
  logic                      pop;
  logic                      flush;
  logic                      fifo_valid;
  logic                      fifo_full;
  logic [PC_W+INSTR_W-1:0]   head;

  assign IM_ADDR   = pc;
  assign pop       = fifo_valid && DEC_READY;
  assign DEC_VALID = fifo_valid;
  assign DEC_PC    = head[PC_W+INSTR_W-1:INSTR_W];
  assign DEC_INSTR = head[INSTR_W-1:0];
  assign HALTED    = (state == HALT);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    flush     = 1'b0;
    if (REDIR_VALID) begin
      flush     = 1'b1;
      pc_nxt    = REDIR_PC & ALIGN_MASK;
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          // A same-cycle pop frees a slot, so a full buffer keeps streaming.
          if (!fifo_full || pop) begin
            push   = 1'b1;
            pc_nxt = pc + PC_W'(2);
            if (IM_Q == HALT_INSTR) state_nxt = HALT_WAIT;
          end
        end
        HALT_WAIT: if (!fifo_valid) state_nxt = HALT;
        HALT:      if (RESUME) state_nxt = RUN;
        default:   state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= RUN;
      pc    <= RESET_PC & ALIGN_MASK;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PC_W + INSTR_W)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .flush     (flush),
    .push      (push),
    .push_data ({pc, IM_Q}),
    .pop       (pop),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .head_data (head)
  );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: a cycle model pushes every expected
// fetch {pc, word} into a scoreboard queue; entries are compared against the
// decode outputs and popped on each handshake. Directed checks cover the
// reset, stall, redirect, halt/resume, wrap and priority scenarios.
module tb_ifetch_ctrl;
  import ifetch_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  IM_ADDR;
  logic [15:0] IM_Q;
  logic        DEC_VALID;
  logic        DEC_READY;
  logic [15:0] DEC_INSTR;
  logic [7:0]  DEC_PC;
  logic        REDIR_VALID;
  logic [7:0]  REDIR_PC;
  logic        RESUME;
  logic        HALTED;

  always #5 CLK = ~CLK;

  logic [15:0] ram [128];
  assign IM_Q = ram[IM_ADDR[7:1]];

  ifetch_ctrl #(
    .DEPTH    (DEPTH),
    .RESET_PC (8'h00)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IM_ADDR     (IM_ADDR),
    .IM_Q        (IM_Q),
    .DEC_VALID   (DEC_VALID),
    .DEC_READY   (DEC_READY),
    .DEC_INSTR   (DEC_INSTR),
    .DEC_PC      (DEC_PC),
    .REDIR_VALID (REDIR_VALID),
    .REDIR_PC    (REDIR_PC),
    .RESUME      (RESUME),
    .HALTED      (HALTED)
  );

  int unsigned ncheck = 0;
  int unsigned nerr   = 0;

  logic [23:0] sb [$];
  logic [7:0]  m_pc;
  state_t      m_st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncheck++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare outputs against the model, advance the model with the current
  // inputs, then step one clock and settle.
  task automatic cycle();
    int unsigned n;
    logic        popd;
    logic [15:0] w;
    n = sb.size();
    chk("im_addr", IM_ADDR, m_pc);
    chk("dec_valid", DEC_VALID, n != 0);
    chk("halted", HALTED, m_st == HALT);
    if (n != 0) begin
      chk("dec_pc", DEC_PC, sb[0][23:16]);
      chk("dec_instr", DEC_INSTR, sb[0][15:0]);
    end else begin
      chk("empty_pc", DEC_PC, 0);
      chk("empty_instr", DEC_INSTR, 0);
    end
    if (RESET) begin
      sb.delete();
      m_pc = 8'h00;
      m_st = RUN;
    end else begin
      popd = (n != 0) && DEC_READY;
      if (popd) void'(sb.pop_front());
      if (REDIR_VALID) begin
        sb.delete();
        m_pc = {REDIR_PC[7:1], 1'b0};
        m_st = RUN;
      end else begin
        case (m_st)
          RUN: begin
            if (n < DEPTH || popd) begin
              w = ram[m_pc[7:1]];
              sb.push_back({m_pc, w});
              m_pc = m_pc + 8'd2;
              if (w == 16'h0001) m_st = HALT_WAIT;
            end
          end
          HALT_WAIT: if (n == 0) m_st = HALT;
          default:   if (RESUME) m_st = RUN;
        endcase
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_halt(input string tag, output logic [7:0] last);
    bit done;
    done = 1'b0;
    last = 8'hxx;
    for (int k = 0; k < 40 && !done; k++) begin
      if (HALTED) done = 1'b1;
      else begin
        if (DEC_VALID && DEC_READY) last = DEC_PC;
        cycle();
      end
    end
    chk(tag, done, 1);
  endtask

  initial begin
    logic [7:0] last;
    for (int i = 0; i < 128; i++) ram[i] = 16'h8000 + 16'(i);
    ram[29] = 16'h0001;

    RESET = 1'b1; DEC_READY = 1'b1; REDIR_VALID = 1'b0; REDIR_PC = 8'h00; RESUME = 1'b0;
    @(posedge CLK);
    #1;
    sb.delete(); m_pc = 8'h00; m_st = RUN;
    cycle();
    chk("rst_valid", DEC_VALID, 0);
    chk("rst_halted", HALTED, 0);
    chk("rst_addr", IM_ADDR, 8'h00);
    chk("rst_pc", DEC_PC, 8'h00);

    // Streaming after reset release
    RESET = 1'b0;
    chk("t1_first_addr", IM_ADDR, 8'h00);
    cycle();
    chk("t1_pc0", DEC_PC, 8'h00); chk("t1_i0", DEC_INSTR, 16'h8000);
    cycle();
    chk("t1_pc1", DEC_PC, 8'h02); chk("t1_i1", DEC_INSTR, 16'h8001);
    cycle();
    chk("t1_pc2", DEC_PC, 8'h04); chk("t1_i2", DEC_INSTR, 16'h8002);

    // Decode stall fills the buffer, then drains without a gap
    RESET = 1'b1; cycle(); RESET = 1'b0;
    DEC_READY = 1'b0;
    repeat (5) cycle();
    chk("t2_valid", DEC_VALID, 1);
    chk("t2_pc", DEC_PC, 8'h00);
    chk("t2_addr", IM_ADDR, 8'h04);
    DEC_READY = 1'b1;
    chk("t2_d0", DEC_PC, 8'h00);
    cycle(); chk("t2_d1", DEC_PC, 8'h02);
    cycle(); chk("t2_d2", DEC_PC, 8'h04);

    // Redirect with a full buffer and a coinciding pop
    DEC_READY = 1'b0;
    repeat (3) cycle();
    REDIR_VALID = 1'b1; REDIR_PC = 8'h29; DEC_READY = 1'b1;
    cycle();
    REDIR_VALID = 1'b0;
    chk("t3_flush", DEC_VALID, 0);
    chk("t3_addr", IM_ADDR, 8'h28);
    cycle();
    chk("t3_pc", DEC_PC, 8'h28);

    // Halt at word 29, then resume
    wait_halt("t4_halt_timeout", last);
    chk("t4_last", last, 8'h3A);
    chk("t4_addr", IM_ADDR, 8'h3C);
    repeat (2) cycle();
    chk("t4_hold_addr", IM_ADDR, 8'h3C);
    chk("t4_hold_halted", HALTED, 1);
    RESUME = 1'b1; cycle(); RESUME = 1'b0;
    chk("t4_run", HALTED, 0);
    cycle();
    chk("t4_resume_pc", DEC_PC, 8'h3C);

    // Address wrap, then reset in the middle of a stall
    REDIR_VALID = 1'b1; REDIR_PC = 8'hFE; cycle(); REDIR_VALID = 1'b0;
    cycle(); chk("t5_fe", DEC_PC, 8'hFE);
    cycle(); chk("t5_wrap", DEC_PC, 8'h00);
    DEC_READY = 1'b0;
    repeat (3) cycle();
    RESET = 1'b1; cycle();
    chk("t5_rst_valid", DEC_VALID, 0);
    RESET = 1'b0; DEC_READY = 1'b1;
    cycle(); chk("t5_restart", DEC_PC, 8'h00);

    // Redirect beats HALT detection in the same cycle
    REDIR_VALID = 1'b1; REDIR_PC = 8'h3A; cycle();
    REDIR_PC = 8'h40; cycle(); REDIR_VALID = 1'b0;
    chk("t6_nohalt_addr", IM_ADDR, 8'h40);
    cycle(); chk("t6_nohalt_pc", DEC_PC, 8'h40);

    // Redirect and RESUME together while halted
    REDIR_VALID = 1'b1; REDIR_PC = 8'h3A; cycle(); REDIR_VALID = 1'b0;
    wait_halt("t6_halt_timeout", last);
    chk("t6_last", last, 8'h3A);
    REDIR_VALID = 1'b1; REDIR_PC = 8'h10; RESUME = 1'b1;
    cycle();
    REDIR_VALID = 1'b0; RESUME = 1'b0;
    chk("t6_halted", HALTED, 0);
    chk("t6_addr", IM_ADDR, 8'h10);
    cycle(); chk("t6_pc", DEC_PC, 8'h10);
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", ncheck, nerr);
    $finish;
  end

endmodule
